// File: rtl/uart_rx_frame.sv
// uart_rx_frame: parametrised UART receiver with majority voting, error flags and a one-deep valid/ready output.
module uart_rx_frame #(
  parameter int BAUD_DIV  = 434,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam logic [15:0] MID  = 16'(BAUD_DIV / 2);
  localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;
  state_t state, state_n;
  logic s0, s1, s2, v0, v1, perr, ferr;
  logic [15:0] bcnt;
  logic [3:0] idx;
  logic [DATA_BITS-1:0] sh;
  logic fall, at_s, at_end, vote, last_data, done;
  assign fall = s2 & ~s1;
  assign at_s = bcnt == MID + 16'd1;
  assign at_end = bcnt == LAST;
  assign vote = (v0 & v1) | (v0 & s1) | (v1 & s1);
  assign last_data = idx == 4'(DATA_BITS - 1);
  always_comb begin
    done = state == STOP && at_s && idx == 4'(STOP_BITS - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // The frame ends at the last stop-bit sample point, leaving half a bit of slack for the next start edge.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = fall ? START : IDLE;
      START:   state_n = (at_s && vote) ? IDLE : at_end ? DATA : START;
      DATA:    state_n = (at_end && last_data) ? (PARITY != 0 ? PAR : STOP) : DATA;
      PAR:     state_n = at_end ? STOP : PAR;
      STOP:    state_n = done ? (vote ? IDLE : BRK) : STOP;
      BRK:     state_n = s1 ? IDLE : BRK;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {s2, s1, s0} <= 3'b111;
      bcnt <= '0;
      idx <= '0;
      v0 <= 1'b0;
      v1 <= 1'b0;
      sh <= '0;
      perr <= 1'b0;
      ferr <= 1'b0;
    end else begin
      {s2, s1, s0} <= {s1, s0, rxd};
      bcnt <= (state_n != state || at_end) ? '0 : bcnt + 16'd1;
      idx <= state_n != state ? '0 : at_end ? idx + 4'd1 : idx;
      if (bcnt == MID - 16'd1) v0 <= s1;
      if (bcnt == MID) v1 <= s1;
      if (state == IDLE) begin
        perr <= 1'b0;
        ferr <= 1'b0;
      end
      if (state == DATA && at_s) sh <= {vote, sh[DATA_BITS-1:1]};
      if (state == PAR && at_s) perr <= ^sh ^ (PARITY == 2) ^ vote;
      if (state == STOP && at_s && !vote) ferr <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
      busy <= 1'b0;
    end else begin
      busy <= state != IDLE;
      if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
        overrun <= 1'b0;
      end
      if (done) begin
        if (dout_valid && !dout_ready) overrun <= 1'b1;
        else begin
          dout <= sh;
          parity_err <= perr;
          frame_err <= ferr | ~vote;
          dout_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed checks of uart_rx_frame in 8N1 and 7E2 configurations at 16 clocks per bit.
module tb_uart_rx_frame;
  logic clk = 1'b0, rst = 1'b1;
  logic rxd_a = 1'b1, ready_a = 1'b0, rxd_b = 1'b1, ready_b = 1'b0;
  logic [7:0] dout_a;
  logic [6:0] dout_b;
  logic valid_a, perr_a, ferr_a, ovr_a, busy_a;
  logic valid_b, perr_b, ferr_b, ovr_b, busy_b;
  int errors = 0, checks = 0, cyc = 0, rise_a = 0, t0;
  logic pv = 1'b0;
  uart_rx_frame #(.BAUD_DIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .rxd(rxd_a), .dout(dout_a), .dout_valid(valid_a), .dout_ready(ready_a),
    .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a), .busy(busy_a));
  uart_rx_frame #(.BAUD_DIV(16), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .rxd(rxd_b), .dout(dout_b), .dout_valid(valid_b), .dout_ready(ready_b),
    .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b), .busy(busy_b));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (valid_a && !pv) rise_a <= cyc;
    pv <= valid_a;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic drv(input bit sel, input logic v);
    if (sel) rxd_b = v;
    else rxd_a = v;
  endtask
  // Bits go out LSB first, 16 clocks each; bit g gets a one-clock low pulse at its midpoint.
  task automatic tx(input bit sel, input logic [15:0] bits, input int n, input int g);
    for (int i = 0; i < n; i++) begin
      drv(sel, bits[i]);
      if (i == g) begin
        tick(8);
        drv(sel, 1'b0);
        tick(1);
        drv(sel, bits[i]);
        tick(7);
      end else tick(16);
    end
  endtask
  task automatic ack(input bit sel);
    if (sel) ready_b = 1'b1;
    else ready_a = 1'b1;
    tick(1);
    ready_a = 1'b0;
    ready_b = 1'b0;
  endtask
  initial begin
    tick(3);
    chk("rst_dout", dout_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_ovr", ovr_a, 0);
    rst = 1'b0;
    tick(5);
    t0 = cyc;
    tx(0, {6'd0, 1'b1, 8'hA5, 1'b0}, 10, -1);
    chk("a5_rise", rise_a, t0 + 157);
    chk("a5_dout", dout_a, 8'hA5);
    chk("a5_valid", valid_a, 1);
    chk("a5_perr", perr_a, 0);
    chk("a5_ferr", ferr_a, 0);
    ack(0);
    chk("a5_drop", valid_a, 0);
    rxd_a = 1'b0;
    tick(4);
    rxd_a = 1'b1;
    tick(12);
    chk("glitch_busy", busy_a, 0);
    chk("glitch_valid", valid_a, 0);
    tick(20);
    tx(0, {6'd0, 1'b1, 8'hFF, 1'b0}, 10, 3);
    chk("ff_dout", dout_a, 8'hFF);
    chk("ff_valid", valid_a, 1);
    ack(0);
    tx(0, {6'd0, 1'b0, 8'h3C, 1'b0}, 10, -1);
    chk("3c_dout", dout_a, 8'h3C);
    chk("3c_ferr", ferr_a, 1);
    chk("3c_valid", valid_a, 1);
    ack(0);
    tick(80);
    chk("brk_valid", valid_a, 0);
    chk("brk_busy", busy_a, 1);
    rxd_a = 1'b1;
    tick(20);
    chk("brk_end_valid", valid_a, 0);
    chk("brk_end_busy", busy_a, 0);
    tx(0, {6'd0, 1'b1, 8'h11, 1'b0}, 10, -1);
    tx(0, {6'd0, 1'b1, 8'h22, 1'b0}, 10, -1);
    chk("ovr_dout", dout_a, 8'h11);
    chk("ovr_set", ovr_a, 1);
    ack(0);
    chk("ovr_clr", ovr_a, 0);
    chk("ovr_valid", valid_a, 0);
    tick(10);
    tx(0, {6'd0, 1'b1, 8'h55, 1'b0}, 10, -1);
    chk("55_dout", dout_a, 8'h55);
    fork
      tx(0, {6'd0, 1'b1, 8'h66, 1'b0}, 10, -1);
      begin
        tick(156);
        ready_a = 1'b1;
        tick(1);
        ready_a = 1'b0;
      end
    join
    chk("coll_dout", dout_a, 8'h66);
    chk("coll_valid", valid_a, 1);
    chk("coll_ovr", ovr_a, 0);
    tx(0, {6'd0, 1'b1, 8'h0F, 1'b0}, 4, -1);
    rxd_a = 1'b1;
    tick(8);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_dout", dout_a, 0);
    chk("mid_rst_valid", valid_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_ferr", ferr_a, 0);
    rst = 1'b0;
    tick(40);
    tx(0, {6'd0, 1'b1, 8'h81, 1'b0}, 10, -1);
    chk("81_dout", dout_a, 8'h81);
    chk("81_valid", valid_a, 1);
    chk("81_ferr", ferr_a, 0);
    tx(1, {5'd0, 1'b1, 1'b1, 1'b0, 7'h41, 1'b0}, 11, -1);
    chk("b41_dout", dout_b, 7'h41);
    chk("b41_valid", valid_b, 1);
    chk("b41_perr", perr_b, 0);
    chk("b41_ferr", ferr_b, 0);
    ack(1);
    tx(1, {5'd0, 1'b1, 1'b1, 1'b1, 7'h41, 1'b0}, 11, -1);
    chk("b41p_dout", dout_b, 7'h41);
    chk("b41p_perr", perr_b, 1);
    ack(1);
    tx(1, {5'd0, 1'b1, 1'b0, 1'b0, 7'h41, 1'b0}, 11, -1);
    chk("b_stop1_ferr", ferr_b, 1);
    chk("b_stop1_perr", perr_b, 0);
    chk("b_stop1_valid", valid_b, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
